// File: rtl/determ_fxp_to_bs.sv
// Deterministic fixed-point to bipolar bitstream encoder: each loaded value becomes
// one N-bit period holding exactly k evenly spread ones (accumulator/threshold rule).
module determ_fxp_to_bs #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned INT_WIDTH   = 1,
  parameter int unsigned PERIOD_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BIT_WIDTH-1:0] x_i,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  output logic                 y_o,
  output logic                 y_valid_o,
  input  logic                 y_ready_i,
  output logic                 y_last_o
);

  localparam int unsigned FracBits = BIT_WIDTH - INT_WIDTH;
  localparam int unsigned Shift    = FracBits + 1 - PERIOD_BITS;
  localparam logic [BIT_WIDTH:0]     Offset  = (BIT_WIDTH + 1)'(1) << FracBits;
  localparam logic [PERIOD_BITS:0]   NFull   = (PERIOD_BITS + 1)'(1) << PERIOD_BITS;
  localparam logic [PERIOD_BITS-1:0] LastIdx = '1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_BITS:0]   k_q, k_d, k_new, sum;
  logic [PERIOD_BITS-1:0] acc_q, acc_d, idx_q, idx_d;
  logic [BIT_WIDTH:0]     u;
  logic                   sat_lo, sat_hi, unused_u;
  logic                   load, beat, last_beat;

  // Bias the signed input into [0, 2^(F+1)) and keep the top PERIOD_BITS bits as k.
  always_comb begin
    u      = {x_i[BIT_WIDTH-1], x_i} + Offset;
    sat_lo = u[BIT_WIDTH];
    sat_hi = (u[BIT_WIDTH-1:0] >> (FracBits + 1)) != '0;
    if (sat_lo) begin
      k_new = '0;
    end else if (sat_hi) begin
      k_new = NFull;
    end else begin
      k_new = {1'b0, u[Shift +: PERIOD_BITS]};
    end
  end

  assign unused_u = ^u;

  assign sum      = {1'b0, acc_q} + k_q;
  assign y_o      = (sum >= NFull);
  assign y_last_o = y_valid_o & (idx_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    x_ready_o = 1'b0;
    y_valid_o = 1'b0;
    last_beat = (idx_q == LastIdx) & y_ready_i;

    unique case (state_q)
      StIdle: x_ready_o = 1'b1;
      StRun: begin
        y_valid_o = 1'b1;
        x_ready_o = last_beat;
      end
      default: ;
    endcase

    if (rst_i) begin
      x_ready_o = 1'b0;
    end

    load = x_valid_i & x_ready_o;
    beat = y_valid_o & y_ready_i;

    // sum < 2N, so dropping the MSB is exactly "subtract N when a one is emitted".
    if (beat) begin
      acc_d = sum[PERIOD_BITS-1:0];
      idx_d = idx_q + 1'b1;
      if (idx_q == LastIdx) begin
        state_d = StIdle;
      end
    end

    if (load) begin
      k_d     = k_new;
      acc_d   = '0;
      idx_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_determ_fxp_to_bs.sv
// Bench for determ_fxp_to_bs: closed-form period model checked every cycle, plus
// literal bit patterns for the documented scenarios and a saturating INT_WIDTH=2 instance.
module tb_determ_fxp_to_bs;

  localparam int N = 8;
  localparam int PB = 3;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic        x_valid, x_ready, y, y_valid, y_ready, y_last;
  logic [15:0] x2;
  logic        x2_valid, x2_ready, y2, y2_valid, y2_ready, y2_last;

  int checks = 0;
  int failures = 0;

  // Bits still owed by the current period; the front entry is the bit on y now.
  bit   q[$];
  logic seen_bits[64];
  int   beat_cyc[64];
  int   nbeats = 0;
  int   cyc = 0;
  logic exp_ready;

  determ_fxp_to_bs #(.BIT_WIDTH(16), .INT_WIDTH(1), .PERIOD_BITS(PB)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .x_i      (x),
    .x_valid_i(x_valid),
    .x_ready_o(x_ready),
    .y_o      (y),
    .y_valid_o(y_valid),
    .y_ready_i(y_ready),
    .y_last_o (y_last)
  );

  determ_fxp_to_bs #(.BIT_WIDTH(16), .INT_WIDTH(2), .PERIOD_BITS(PB)) u_dut2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .x_i      (x2),
    .x_valid_i(x2_valid),
    .x_ready_o(x2_ready),
    .y_o      (y2),
    .y_valid_o(y2_valid),
    .y_ready_i(y2_ready),
    .y_last_o (y2_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of ones per period from the real value of x.
  function automatic int model_k(input logic [15:0] xv, input int iw);
    int f;
    int xi;
    f  = 16 - iw;
    xi = $signed(xv);
    if (xi >= (1 << f)) return N;
    if (xi < -(1 << f)) return 0;
    return (xi + (1 << f)) / (1 << (f + 1 - PB));
  endfunction

  // Evenly spread ones: bit i is set when floor((i+1)k/N) steps past floor(ik/N).
  function automatic bit model_bit(input int k, input int i);
    return bit'(((i + 1) * k / N) - (i * k / N));
  endfunction

  function automatic logic [7:0] collect(input int s);
    logic [7:0] p;
    for (int j = 0; j < 8; j++) p[j] = seen_bits[(s + j) % 64];
    return p;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        exp_ready = 1'b0;
        check("rst_y_valid", y_valid, 0);
        check("rst_x_ready", x_ready, 0);
        check("rst_y", y, 0);
        check("rst_y_last", y_last, 0);
      end else begin
        exp_ready = (q.size() == 0) || (q.size() == 1 && y_ready);
        check("x_ready", x_ready, exp_ready);
        check("y_valid", y_valid, q.size() != 0);
        if (q.size() != 0) begin
          check("y", y, q[0]);
          check("y_last", y_last, q.size() == 1);
          if (y_ready) begin
            seen_bits[nbeats % 64] = y;
            beat_cyc[nbeats % 64]  = cyc;
            nbeats++;
          end
        end
      end
      @(posedge clk);
      if (!rst) begin
        if (q.size() != 0 && y_ready) void'(q.pop_front());
        if (x_valid && exp_ready) begin
          for (int i = 0; i < N; i++) q.push_back(model_bit(model_k(x, 1), i));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    logic acc;
    int   n;
    n       = 0;
    x       = v;
    x_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = x_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    x_valid = 1'b0;
    x       = 16'($urandom);
    check("load_accept", acc, 1);
  endtask

  task automatic wait_beats(input int target, input string name);
    int n;
    n = 0;
    while (nbeats < target && n < 100) begin
      tick();
      n++;
    end
    check({name, "_beats"}, nbeats >= target, 1);
  endtask

  task automatic run_period(input logic [15:0] v, input logic [7:0] exp_pat, input string name);
    int s;
    s = nbeats;
    load(v);
    wait_beats(s + 8, name);
    check({name, "_pattern"}, collect(s), exp_pat);
    @(negedge clk);
    check({name, "_idle_ready"}, x_ready, 1);
    check({name, "_idle_valid"}, y_valid, 0);
    tick();
  endtask

  task automatic iw2_period(input logic [15:0] v, input logic [7:0] exp_pat, input string name);
    logic [7:0] pat;
    logic [7:0] mpat;
    pat = '0;
    for (int j = 0; j < 8; j++) mpat[j] = model_bit(model_k(v, 2), j);
    x2       = v;
    x2_valid = 1'b1;
    tick();
    x2_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check({name, "_valid"}, y2_valid, 1);
      check({name, "_last"}, y2_last, j == 7);
      pat[j] = y2;
    end
    @(negedge clk);
    check({name, "_idle"}, y2_valid, 0);
    tick();
    check(name, pat, exp_pat);
    check({name, "_model"}, pat, mpat);
  endtask

  initial begin
    int s;
    rst = 1'b1; x = '0; x_valid = 1'b0; y_ready = 1'b1;
    x2 = '0; x2_valid = 1'b0; y2_ready = 1'b1;

    check("model_k_zero", model_k(16'h0000, 1), 4);
    check("model_k_half", model_k(16'h4000, 1), 6);
    check("model_k_neg1", model_k(16'h8000, 1), 0);
    check("model_k_max", model_k(16'h7FFF, 1), 7);
    check("model_k_neghalf", model_k(16'hC000, 1), 2);
    check("model_k_iw2_sat", model_k(16'h4000, 2), 8);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_period(16'h0000, 8'hAA, "k4");
    run_period(16'h4000, 8'hEE, "k6");
    run_period(16'h8000, 8'h00, "k0");
    run_period(16'h7FFF, 8'hFE, "k7");

    s = nbeats;
    load(16'h4000);
    load(16'hC000);
    wait_beats(s + 16, "b2b");
    check("b2b_first", collect(s), 8'hEE);
    check("b2b_second", collect(s + 8), 8'h88);
    check("b2b_contiguous", beat_cyc[(s + 15) % 64] - beat_cyc[s % 64], 15);
    tick();

    s = nbeats;
    load(16'h0000);
    wait_beats(s + 2, "bp_pre");
    y_ready = 1'b0;
    repeat (3) tick();
    check("bp_stalled", nbeats, s + 2);
    y_ready = 1'b1;
    wait_beats(s + 8, "bp_post");
    check("bp_pattern", collect(s), 8'hAA);
    check("bp_ones", $countones(collect(s)), 4);
    tick();

    s = nbeats;
    load(16'h4000);
    wait_beats(s + 5, "rst_pre");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_discard", nbeats, s + 5);
    run_period(16'h0000, 8'hAA, "after_rst");

    iw2_period(16'h4000, 8'hFF, "iw2_pos_sat");
    iw2_period(16'hBFFF, 8'h00, "iw2_neg_sat");
    iw2_period(16'h2000, 8'hEE, "iw2_half");

    for (int it = 0; it < 1500; it++) begin
      x       = 16'($urandom);
      x_valid = 1'($urandom_range(0, 1));
      y_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/determ_fxp_to_bs.md
DETERM_FXP_TO_BS -- requirements
Module: determ_fxp_to_bs

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of the signed fixed-point input word.
REQ-002 Parameter INT_WIDTH, default 1: integer bits including sign; F = BIT_WIDTH - INT_WIDTH fraction bits.
REQ-003 Parameter PERIOD_BITS, default 4: bitstream period N = 2^PERIOD_BITS; legal range 1 <= PERIOD_BITS <= F+1.
REQ-004 CLK  input  1: single clock; all state updates on the rising edge.
REQ-005 RST  input  1: reset, asynchronous and active-high.
REQ-006 x  input  BIT_WIDTH: signed fixed-point value to encode, two's complement, F fraction bits.
REQ-007 x_valid  input  1: x is presented for loading.
REQ-008 x_ready  output  1: block accepts x this cycle.
REQ-009 y  output  1: deterministic bipolar bitstream bit (1 = +1, 0 = -1).
REQ-010 y_valid  output  1: y holds a valid bit.
REQ-011 y_ready  input  1: downstream consumes y this cycle.
REQ-012 y_last  output  1: y is the final bit (index N-1) of the current period.

Function
REQ-013 Two states, IDLE and RUN; load handshake = x_valid & x_ready; output beat = y_valid & y_ready.
REQ-014 IDLE: x_ready = 1, y_valid = 0; on a load, capture k, clear acc and index i, go to RUN.
REQ-015 RUN: y_valid = 1; x_ready = 1 only on the final beat (i = N-1 and y_ready = 1), otherwise 0.
REQ-016 Count k (PERIOD_BITS+1 bits): let u = x_int + 2^F evaluated at BIT_WIDTH+1 bits; k = u >> (F+1-PERIOD_BITS).
REQ-017 Saturation when INT_WIDTH > 1: x_int >= 2^F gives k = N; x_int < -2^F gives k = 0.
REQ-018 Bit rule at index i: s = acc + k; y = (s >= N); y_last = (i = N-1); y, y_valid and y_last are combinational from the registered acc, k and i.
REQ-019 On each beat: acc <= s - N*y; i <= i+1, wrapping N-1 -> 0.
REQ-020 Each period therefore emits exactly k ones in N bits, spread evenly; acc returns to 0 at period end.
REQ-021 No beat (y_ready = 0): acc, i, k and y are held stable; y_valid stays 1.
REQ-022 Final beat with load: capture the new k, clear acc and i, remain in RUN; no idle cycle between periods.
REQ-023 Final beat without load: go to IDLE.
REQ-024 Latency: x loaded at edge t gives the first y_valid in the cycle after t; throughput is 1 bit per cycle.
REQ-025 x is sampled only on a load; changes to x during RUN have no effect.

Reset
REQ-026 RST asserted, at any time including mid-period: state = IDLE, acc = 0, i = 0, k = 0.
REQ-027 Outputs during reset: y_valid = 0, y = 0, y_last = 0, x_ready = 0.
REQ-028 A partial period interrupted by reset is discarded, with no further beats.
REQ-029 First load is possible on the first rising edge after RST deasserts.

Verification (BIT_WIDTH=16, INT_WIDTH=1, PERIOD_BITS=3, N=8, y_ready=1 unless stated)
REQ-030 Load x=0x0000 -> k=4; y = 0,1,0,1,0,1,0,1; y_last on bit 8; then IDLE with x_ready=1.
REQ-031 Load x=0x4000 (+0.5) -> k=6; y = 0,1,1,1,0,1,1,1. Load x=0x8000 (-1.0) -> all 0. Load x=0x7FFF -> k=7; y = 0,1,1,1,1,1,1,1.
REQ-032 Back-to-back: 0x4000 then 0xC000 (-0.5, k=2) presented on the final beat -> 16 contiguous valid bits, second period 0,0,0,1,0,0,0,1, no gap.
REQ-033 Backpressure: x=0x0000 with y_ready low for 3 cycles after bit 2 -> y, y_last and y_valid held; the sequence resumes unchanged; total ones = 4.
REQ-034 RST pulsed after bit 5 of x=0x4000 -> y_valid=0 immediately; a fresh load of 0x0000 yields 0,1,0,1,0,1,0,1.
REQ-035 INT_WIDTH=2, x_int=+2^F (+1.0) -> k=8, all ones; x_int=-2^F-1 -> k=0, all zeros.
